// File: rtl/iter_shifter_pkg.sv
// iter_shifter_pkg: shared definitions for the iterative shifter.
//   - MODE_* : 2-bit shift-mode encodings (SLL, SRL, SRA, ROL)
//   - state_e: controller states (ST_IDLE, ST_BUSY, ST_DONE)
//   - params_ok(): elaboration-time sanity check of WIDTH/STEP
// Optional feature macro: ITER_SHIFTER_ROTATE_EN (enables ROL for mode 11).
package iter_shifter_pkg;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // WIDTH: power of two, >= 8. STEP: power of two, 1..WIDTH.
  function automatic bit params_ok(input int unsigned width, input int unsigned step);
    return is_pow2(width) && (width >= 8) && is_pow2(step) && (step >= 1) && (step <= width);
  endfunction

endpackage

// File: rtl/iter_shifter_step.sv
// shift_step: single combinational shift stage for iter_shifter.
//   data_i : operand
//   amt_i  : shift distance, 0..STEP
//   mode_i : MODE_SLL / MODE_SRL / MODE_SRA / MODE_ROL
//   fill_i : sign bit used as MSB fill for SRA
//   data_o : shifted result
// Optional feature macro: ITER_SHIFTER_ROTATE_EN (ROL datapath only built when defined;
// otherwise mode 11 shifts as SLL).
module shift_step
  import iter_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned STEP  = 16,
  parameter int unsigned AMT_W = $clog2(STEP) + 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [AMT_W-1:0] amt_i,
  input  logic [1:0]       mode_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] data_o
);

  logic [2*WIDTH-1:0] wide;

  always_comb begin
    wide   = '0;
    data_o = '0;
    case (mode_i)
      MODE_SLL: data_o = data_i << amt_i;
      MODE_SRL: data_o = data_i >> amt_i;
      MODE_SRA: begin
        // Shift a sign-extended double-width copy so the fill comes from the latched MSB.
        wide   = {{WIDTH{fill_i}}, data_i} >> amt_i;
        data_o = wide[WIDTH-1:0];
      end
`ifdef ITER_SHIFTER_ROTATE_EN
      MODE_ROL: begin
        // Upper half of the doubled operand shifted left is the rotated word.
        wide   = {data_i, data_i} << amt_i;
        data_o = wide[2*WIDTH-1:WIDTH];
      end
`endif
      default:  data_o = data_i << amt_i;
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle WIDTH-bit shifter applying up to STEP positions per clock.
//   clock, reset_n       : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    : request handshake; in_a operand, in_shamt amount, in_mode mode
//   out_valid/out_ready  : result handshake; out_result shifted value
//   busy                 : high while a request is in flight (BUSY or DONE)
// Optional feature macro: ITER_SHIFTER_ROTATE_EN (mode 11 = ROL; otherwise treated as SLL).
module iter_shifter
  import iter_shifter_pkg::*;
#(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned STEP    = 16,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic               busy
);

  localparam bit          PARAMS_OK = params_ok(WIDTH, STEP);
  localparam int unsigned AMT_W     = $clog2(STEP) + 1;

  generate
    if (!PARAMS_OK) begin : g_param_err
      $error("iter_shifter: WIDTH must be a power of two >= 8, STEP a power of two in 1..WIDTH");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [1:0]         mode_q, mode_d;
  logic               sign_q, sign_d;

  logic               rem_ge_step;
  logic [AMT_W-1:0]   step_amt;
  logic [WIDTH-1:0]   step_out;
  logic [1:0]         mode_in_eff;

  // Compare at 32 bits: STEP may equal WIDTH and not fit in SHAMT_W.
  assign rem_ge_step = (32'(rem_q) >= STEP);
  assign step_amt    = rem_ge_step ? AMT_W'(STEP) : AMT_W'(rem_q);

`ifdef ITER_SHIFTER_ROTATE_EN
  assign mode_in_eff = in_mode;
`else
  assign mode_in_eff = (in_mode == MODE_ROL) ? MODE_SLL : in_mode;
`endif

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .AMT_W (AMT_W)
  ) u_step (
    .data_i (data_q),
    .amt_i  (step_amt),
    .mode_i (mode_q),
    .fill_i (sign_q),
    .data_o (step_out)
  );

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    result_d = result_q;
    rem_d    = rem_q;
    mode_d   = mode_q;
    sign_d   = sign_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = in_a;
          rem_d   = in_shamt;
          mode_d  = mode_in_eff;
          sign_d  = in_a[WIDTH-1];
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        data_d = step_out;
        if (rem_ge_step) begin
          rem_d = rem_q - SHAMT_W'(STEP);
        end else begin
          rem_d    = '0;
          result_d = step_out;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      result_q <= '0;
      rem_q    <= '0;
      mode_q   <= '0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      mode_q   <= mode_d;
      sign_q   <= sign_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign out_result = result_q;

endmodule

// File: tb/tb_iter_shifter.sv
// tb_iter_shifter: directed self-checking bench for iter_shifter (WIDTH=64, STEP=16).
// Honours ITER_SHIFTER_ROTATE_EN when choosing the expected mode-11 result.
module tb_iter_shifter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_a = '0;
  logic [5:0]  in_shamt = '0;
  logic [1:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_result;
  logic        busy;

  int unsigned tests = 0;
  int unsigned fails = 0;

  iter_shifter #(.WIDTH(64), .STEP(16)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_shamt   (in_shamt),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, check latency/result, optionally hold DONE under backpressure, then drain.
  task automatic run_req(input string tag, input logic [63:0] a, input logic [5:0] sh,
                         input logic [1:0] mode, input logic [63:0] exp,
                         input int unsigned lat, input int unsigned hold);
    int unsigned cyc;
    @(negedge clock);
    check({tag, "_pre_ready"}, 64'(in_ready), 64'd1);
    in_a = a; in_shamt = sh; in_mode = mode; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    in_a = ~a; in_shamt = ~sh; in_mode = ~mode;   // latched copies must be used
    cyc = 0;
    while (!out_valid && cyc < 64) begin
      check({tag, "_busy_ready"}, {62'd0, in_ready, busy}, 64'b01);
      @(posedge clock); #1;
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(lat));
    check({tag, "_result"}, out_result, exp);
    for (int i = 0; i < int'(hold); i++) begin
      in_valid = i[0];
      in_a     = 64'hDEAD_BEEF_0000_0000 | 64'(i);
      @(posedge clock); #1;
      check({tag, "_hold_state"}, {61'd0, out_valid, in_ready, busy}, 64'b101);
      check({tag, "_hold_result"}, out_result, exp);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check({tag, "_drain_state"}, {61'd0, out_valid, in_ready, busy}, 64'b010);
    check({tag, "_drain_result"}, out_result, exp);
  endtask

  initial begin
    #2;
    check("reset_state", {61'd0, out_valid, in_ready, busy}, 64'b010);
    check("reset_result", out_result, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    run_req("sll16", 64'h0000_0000_0000_00FF, 6'd16, 2'b00, 64'h0000_0000_00FF_0000, 2, 0);
    run_req("sra63", 64'h8000_0000_0000_0000, 6'd63, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 4, 0);
    run_req("srl63", 64'h8000_0000_0000_0000, 6'd63, 2'b01, 64'h0000_0000_0000_0001, 4, 0);
    run_req("srl0",  64'h1234_5678_9ABC_DEF0, 6'd0,  2'b01, 64'h1234_5678_9ABC_DEF0, 1, 0);
    run_req("sra15", 64'hF000_0000_0000_0000, 6'd15, 2'b10, 64'hFFFF_E000_0000_0000, 1, 0);
`ifdef ITER_SHIFTER_ROTATE_EN
    run_req("mode11", 64'h8000_0000_0000_0001, 6'd4, 2'b11, 64'h0000_0000_0000_0018, 1, 0);
`else
    run_req("mode11", 64'h8000_0000_0000_0001, 6'd4, 2'b11, 64'h0000_0000_0000_0010, 1, 0);
`endif

    // Backpressure: five stalled DONE cycles with in_valid pulses that must be ignored.
    run_req("bp", 64'h0000_0000_0000_0F0F, 6'd20, 2'b00, 64'h0000_0000_F0F0_0000, 2, 5);
    @(posedge clock); #1;
    check("bp_idle_after", {61'd0, out_valid, in_ready, busy}, 64'b010);

    // Reset in the middle of BUSY: outputs return immediately, no result emerges.
    @(negedge clock);
    in_a = 64'h8000_0000_0000_0000; in_shamt = 6'd63; in_mode = 2'b10; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #2;
    check("midreset_busy", {61'd0, out_valid, in_ready, busy}, 64'b001);
    reset_n = 1'b0;
    #1;
    check("midreset_state", {61'd0, out_valid, in_ready, busy}, 64'b010);
    check("midreset_result", out_result, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    check("postreset_idle", {61'd0, out_valid, in_ready, busy}, 64'b010);
    run_req("postreset", 64'h0000_0000_0000_0001, 6'd40, 2'b00, 64'h0000_0100_0000_0000, 3, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
